// File: rtl/siphash_msg_ctrl_if.sv
// Handshake bundle between the message source, the SipHash message controller and the core.
// The slave modport is the controller's view; master is the source/core side.
interface siphash_msg_ctrl_if;
  logic        start;
  logic        msg_empty;
  logic        long;
  logic        msg_valid;
  logic [7:0]  msg_data;
  logic        msg_last;
  logic        msg_ready;
  logic        core_initalize;
  logic        core_compress;
  logic        core_finalize;
  logic        core_long;
  logic [63:0] core_mi;
  logic        core_ready;
  logic        core_word_valid;
  logic        busy;
  logic        done;

  modport slave (
    input  start, msg_empty, long, msg_valid, msg_data, msg_last,
    input  core_ready, core_word_valid,
    output msg_ready, core_initalize, core_compress, core_finalize,
    output core_long, core_mi, busy, done
  );

  modport master (
    output start, msg_empty, long, msg_valid, msg_data, msg_last,
    output core_ready, core_word_valid,
    input  msg_ready, core_initalize, core_compress, core_finalize,
    input  core_long, core_mi, busy, done
  );
endinterface

// File: rtl/siphash_msg_ctrl.sv
// Packs a byte stream into little-endian 64-bit SipHash words, appends the length byte
// and sequences the init/compress/finalize pulses to the SipHash core.
module siphash_msg_ctrl (
  input  logic                 clk,
  input  logic                 reset_n,
  siphash_msg_ctrl_if.slave    bus
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] INIT       = 4'd1;
  localparam logic [3:0] COLLECT    = 4'd2;
  localparam logic [3:0] COMP       = 4'd3;
  localparam logic [3:0] COMP_WAIT  = 4'd4;
  localparam logic [3:0] PAD        = 4'd5;
  localparam logic [3:0] FINAL      = 4'd6;
  localparam logic [3:0] FINAL_WAIT = 4'd7;
  localparam logic [3:0] DONE       = 4'd8;

  logic [3:0]  state;
  logic [63:0] word_reg;
  logic [2:0]  byte_ctr;
  logic [7:0]  len_ctr;
  logic        final_flag;
  logic        pad_pending;
  logic        empty_flag;
  logic        long_reg;
  logic        wait_skip;

  logic        accept;
  logic [7:0]  len_inc;
  logic [63:0] word_fill;

  // Lanes above the current byte are already zero, so a short final word only needs the length in lane 7.
  always_comb begin
    accept    = bus.msg_valid && (state == COLLECT);
    len_inc   = len_ctr + 8'd1;
    word_fill = word_reg;
    word_fill[{byte_ctr, 3'b000} +: 8] = bus.msg_data;
    if (bus.msg_last && (byte_ctr != 3'd7)) begin
      word_fill[63:56] = len_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      word_reg    <= 64'h0;
      byte_ctr    <= 3'd0;
      len_ctr     <= 8'd0;
      final_flag  <= 1'b0;
      pad_pending <= 1'b0;
      empty_flag  <= 1'b0;
      long_reg    <= 1'b0;
      wait_skip   <= 1'b0;
    end else begin
      wait_skip <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.core_ready) begin
            long_reg   <= bus.long;
            empty_flag <= bus.msg_empty;
            state      <= INIT;
          end
        end
        INIT: begin
          word_reg    <= 64'h0;
          byte_ctr    <= 3'd0;
          len_ctr     <= 8'd0;
          final_flag  <= 1'b0;
          pad_pending <= 1'b0;
          state       <= empty_flag ? PAD : COLLECT;
        end
        COLLECT: begin
          if (accept) begin
            word_reg <= word_fill;
            byte_ctr <= byte_ctr + 3'd1;
            len_ctr  <= len_inc;
            if (byte_ctr == 3'd7) begin
              pad_pending <= bus.msg_last;
              final_flag  <= 1'b0;
              state       <= COMP;
            end else if (bus.msg_last) begin
              final_flag <= 1'b1;
              state      <= COMP;
            end
          end
        end
        PAD: begin
          word_reg    <= {len_ctr, 56'h0};
          final_flag  <= 1'b1;
          pad_pending <= 1'b0;
          state       <= COMP;
        end
        COMP: begin
          wait_skip <= 1'b1;
          state     <= COMP_WAIT;
        end
        // The core may still report ready in the cycle right after a pulse, hence the skip cycle.
        COMP_WAIT: begin
          if (!wait_skip && bus.core_ready) begin
            if (pad_pending) begin
              state <= PAD;
            end else if (final_flag) begin
              state <= FINAL;
            end else begin
              word_reg <= 64'h0;
              byte_ctr <= 3'd0;
              state    <= COLLECT;
            end
          end
        end
        FINAL: begin
          wait_skip <= 1'b1;
          state     <= FINAL_WAIT;
        end
        FINAL_WAIT: begin
          if (!wait_skip && bus.core_word_valid) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.msg_ready      = (state == COLLECT);
  assign bus.core_initalize = (state == INIT);
  assign bus.core_compress  = (state == COMP);
  assign bus.core_finalize  = (state == FINAL);
  assign bus.core_long      = long_reg;
  assign bus.core_mi        = word_reg;
  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);

endmodule
